// File: rtl/contador_duzias_pkg.sv
// Shared production-line constants and types for the bottle line stages.
//   CLK_HZ              system clock frequency
//   TEMPO_EMBALAGEM     packing actuator hold time in cycles (0.5 s)
//   GARRAFAS_POR_DUZIA  bottles per dozen
//   MAX_DUZIAS          dozen-count saturation value (two BCD digits)
//   estado_t            dozen-counter state encodings
//   bcd2bin             two BCD digits -> integer value
package contador_duzias_pkg;

  localparam int CLK_HZ             = 50_000_000;
  localparam int TEMPO_EMBALAGEM    = CLK_HZ / 2;
  localparam int GARRAFAS_POR_DUZIA = 12;
  localparam int MAX_DUZIAS         = 99;
  localparam int TIMER_W            = 26;

  typedef enum logic [1:0] {
    CONTANDO  = 2'd0,
    EMBALANDO = 2'd1,
    CHEIO     = 2'd2
  } estado_t;

  function automatic int bcd2bin(input logic [3:0] dez, input logic [3:0] uni);
    return int'(dez) * 10 + int'(uni);
  endfunction

endpackage

// File: rtl/contador_duzias_detector_borda.sv
// Registered rising-edge detector.
//   clk    system clock
//   reset  asynchronous, active-high
//   in     level input
//   pulso  high during the first cycle 'in' is seen high
module detector_borda (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulso
);

  logic r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prev <= 1'b0;
    else       r_prev <= in;
  end

  assign pulso = in & ~r_prev;

endmodule

// File: rtl/contador_duzias.sv
// Dozen counter for approved bottles. Counts rising edges of garrafa_aprovada,
// groups them into dozens shown as two BCD digits, holds the packing actuator
// for TEMPO_EMBALAGEM cycles after each dozen and saturates at MAX_DUZIAS.
//   clk               system clock
//   reset             asynchronous, active-high
//   garrafa_aprovada  approved-bottle level from the QC stage
//   zerar_contagem    synchronous clear of all counts
//   unidades          bottles in the current dozen (binary)
//   duzias_dezena     BCD tens digit of completed dozens
//   duzias_unidade    BCD units digit of completed dozens
//   duzia_completa    one-cycle pulse when a dozen completes
//   embalando         packing actuator (state EMBALANDO)
//   limite_atingido   dozen count saturated (state CHEIO)
module contador_duzias
  import contador_duzias_pkg::*;
#(
  parameter int GARRAFAS_POR_DUZIA = contador_duzias_pkg::GARRAFAS_POR_DUZIA,
  parameter int MAX_DUZIAS         = contador_duzias_pkg::MAX_DUZIAS,
  parameter int TEMPO_EMBALAGEM    = contador_duzias_pkg::TEMPO_EMBALAGEM
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       garrafa_aprovada,
  input  logic       zerar_contagem,
  output logic [3:0] unidades,
  output logic [3:0] duzias_dezena,
  output logic [3:0] duzias_unidade,
  output logic       duzia_completa,
  output logic       embalando,
  output logic       limite_atingido
);

  localparam logic [3:0]         UNI_ULTIMA   = 4'(GARRAFAS_POR_DUZIA - 1);
  localparam logic [TIMER_W-1:0] TEMPO_ULTIMO = TIMER_W'(TEMPO_EMBALAGEM - 1);

  estado_t            r_estado, w_estado_nxt;
  logic [3:0]         r_unidades, w_unidades_nxt;
  logic [3:0]         r_dezena, w_dezena_nxt;
  logic [3:0]         r_duz_uni, w_duz_uni_nxt;
  logic [TIMER_W-1:0] r_timer, w_timer_nxt;
  logic               r_completa, w_completa_nxt;
  logic               w_evento;
  logic [3:0]         w_dez_inc, w_uni_inc;

  detector_borda u_borda (
    .clk   (clk),
    .reset (reset),
    .in    (garrafa_aprovada),
    .pulso (w_evento)
  );

  // BCD dozen + 1, units digit wraps 9 -> 0 carrying into the tens digit
  assign w_uni_inc = (r_duz_uni == 4'd9) ? 4'd0 : r_duz_uni + 4'd1;
  assign w_dez_inc = (r_duz_uni == 4'd9) ? r_dezena + 4'd1 : r_dezena;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado   <= CONTANDO;
      r_unidades <= '0;
      r_dezena   <= '0;
      r_duz_uni  <= '0;
      r_timer    <= '0;
      r_completa <= 1'b0;
    end else begin
      r_estado   <= w_estado_nxt;
      r_unidades <= w_unidades_nxt;
      r_dezena   <= w_dezena_nxt;
      r_duz_uni  <= w_duz_uni_nxt;
      r_timer    <= w_timer_nxt;
      r_completa <= w_completa_nxt;
    end
  end

  always_comb begin
    w_estado_nxt   = r_estado;
    w_unidades_nxt = r_unidades;
    w_dezena_nxt   = r_dezena;
    w_duz_uni_nxt  = r_duz_uni;
    w_timer_nxt    = r_timer;
    w_completa_nxt = 1'b0;
    case (r_estado)
      CONTANDO, EMBALANDO: begin
        if (r_estado == EMBALANDO) begin
          if (r_timer == TEMPO_ULTIMO) begin
            w_estado_nxt = CONTANDO;
            w_timer_nxt  = '0;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end
        // Clear overrides both the timer and any bottle edge this cycle
        if (zerar_contagem) begin
          w_estado_nxt   = CONTANDO;
          w_unidades_nxt = '0;
          w_dezena_nxt   = '0;
          w_duz_uni_nxt  = '0;
          w_timer_nxt    = '0;
        end else if (w_evento) begin
          if (r_unidades == UNI_ULTIMA) begin
            w_unidades_nxt = '0;
            w_dezena_nxt   = w_dez_inc;
            w_duz_uni_nxt  = w_uni_inc;
            w_completa_nxt = 1'b1;
            w_timer_nxt    = '0;
            // A dozen completing mid-packing restarts the hold time
            if (bcd2bin(w_dez_inc, w_uni_inc) == MAX_DUZIAS) w_estado_nxt = CHEIO;
            else                                             w_estado_nxt = EMBALANDO;
          end else begin
            w_unidades_nxt = r_unidades + 4'd1;
          end
        end
      end
      CHEIO: begin
        // Frozen until cleared; bottle edges are ignored
        if (zerar_contagem) begin
          w_estado_nxt   = CONTANDO;
          w_unidades_nxt = '0;
          w_dezena_nxt   = '0;
          w_duz_uni_nxt  = '0;
          w_timer_nxt    = '0;
        end
      end
      default: begin
        w_estado_nxt   = CONTANDO;
        w_unidades_nxt = '0;
        w_dezena_nxt   = '0;
        w_duz_uni_nxt  = '0;
        w_timer_nxt    = '0;
      end
    endcase
  end

  assign unidades        = r_unidades;
  assign duzias_dezena   = r_dezena;
  assign duzias_unidade  = r_duz_uni;
  assign duzia_completa  = r_completa;
  assign embalando       = (r_estado == EMBALANDO);
  assign limite_atingido = (r_estado == CHEIO);

endmodule
